pixel_stream_packer: RTL
========================

PIXEL_STREAM_PACKER -- requirements
Module: pixel_stream_packer

Interface
REQ-001 SHALL have parameter COLOR_BITS, default 24: packed RGB width, 3 equal channels.
REQ-002 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16: FIFO entries, power of two, at least 4.
REQ-005 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port display_enable_i, input, 1: current pixel is in the visible area.
REQ-008 SHALL have ports hpos_i and vpos_i, input, 10 each: current pixel coordinates.
REQ-009 SHALL have ports red_i, green_i, blue_i, input, COLOR_BITS/3 each: pixel colour.
REQ-010 SHALL have port tdata_o, output, COLOR_BITS: packed pixel {red, green, blue}, red in the MSBs.
REQ-011 SHALL have port tuser_o, output, 1: start of frame, set on pixel (0,0).
REQ-012 SHALL have port tlast_o, output, 1: end of line, set on pixel hpos = H_ACTIVE-1.
REQ-013 SHALL have port tvalid_o, output, 1: output word valid.
REQ-014 SHALL have port tready_i, input, 1: downstream accepts the word.
REQ-015 SHALL have port overflow_o, output, 1: sticky flag, a pixel was dropped.
REQ-016 SHALL have port frame_count_o, output, 16: number of frames admitted.

Function
REQ-017 SHALL sample a pixel on each rising edge where display_enable_i=1, and ignore all other cycles.
REQ-018 SHALL tag the sampled pixel with sof = (hpos_i=0 and vpos_i=0) and eol = (hpos_i=H_ACTIVE-1).
REQ-019 SHALL use a three-state FSM with states WAIT_SOF, STREAM and DROP.
REQ-020 In WAIT_SOF, SHALL discard non-sof pixels, push the sof pixel and move to STREAM.
REQ-021 In STREAM, SHALL push every sampled pixel.
REQ-022 In STREAM, a push while the FIFO is full with no pop in the same cycle SHALL drop that pixel, set overflow_o and move to DROP.
REQ-023 In DROP, SHALL discard all pixels until a sof pixel arrives; that sof pixel SHALL be pushed if the FIFO is not full and the FSM moves to STREAM, otherwise it stays in DROP.
REQ-024 A push and a pop in the same cycle when full SHALL both succeed, with no overflow.
REQ-025 FIFO SHALL be show-ahead: tvalid_o = not empty, and tdata_o, tuser_o, tlast_o come from the head entry.
REQ-026 Latency SHALL be one cycle: a pixel pushed at edge N, into an empty FIFO, appears on the outputs after edge N.
REQ-027 A pop SHALL occur on an edge where tvalid_o=1 and tready_i=1.
REQ-028 While tvalid_o=1 and tready_i=0, the outputs SHALL hold stable.
REQ-029 Pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, with the extra bit used for full/empty, wrapping modulo 2*FIFO_DEPTH.
REQ-030 frame_count_o SHALL increment by 1 on each pushed sof pixel, wrapping from 65535 to 0.
REQ-031 overflow_o SHALL clear only on reset.
REQ-032 A tready_i asserted while empty SHALL have no effect.

Reset
REQ-033 While rst_i=1, the block SHALL hold: state=WAIT_SOF, pointers=0, tvalid_o=0, overflow_o=0, frame_count_o=0.
REQ-034 Reset asserted mid-frame SHALL flush the FIFO immediately.
REQ-035 After reset releases, output SHALL resume only at the next sof pixel.
REQ-036 tdata_o, tuser_o and tlast_o SHALL be don't-care while tvalid_o=0.

Structure
REQ-037 A shared package game_pkg SHALL hold the FSM state enum and the pixel entry struct {sof, eol, rgb}.
REQ-038 game_pkg SHALL hold the H_ACTIVE and V_ACTIVE defaults, shared with the sync generator.
REQ-039 The FIFO SHALL be one sub-module, sync_fifo, with ports push, pop, full, empty and head data; the FSM, tagging and counter stay in the top.

Verification
REQ-040 Reset, tready_i=1, 640x480 frame -> 307200 words, first with tuser_o=1, 480 with tlast_o=1, frame_count_o=1, overflow_o=0.
REQ-041 Release reset mid-frame at hpos=100, vpos=37 -> no tvalid_o until (0,0); first output word has tuser_o=1.
REQ-042 tready_i=0 for 20 pixels with FIFO_DEPTH=16 -> 16 words stored; 17th dropped; overflow_o=1; no output until next sof pixel accepted.
REQ-043 FIFO full, push and pop in the same cycle -> no overflow, occupancy stays 16, words come out in order.
REQ-044 tready_i toggling 1/0 each cycle over one line -> 640 words in order, outputs stable while tready_i=0, last word has tlast_o=1.
REQ-045 frame_count_o preloaded near wrap, 2 frames after 65535 -> count 65535 -> 0 -> 1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared video definitions: timing defaults, packer FSM states and FIFO entry layout.
package game_pkg;

    // Default visible area, shared with the sync generator
    localparam int H_ACTIVE_DEF   = 640;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int COLOR_BITS_DEF = 24;

    // Packer admission states
    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        STREAM   = 2'd1,
        DROP     = 2'd2
    } pk_state_e;

    // One FIFO entry at the default colour depth. The packer stores the same
    // {sof, eol, rgb} layout as a flat vector so it can follow COLOR_BITS.
    typedef struct packed {
        logic                      sof;
        logic                      eol;
        logic [COLOR_BITS_DEF-1:0] rgb;
    } pix_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead single-clock FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 26
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside a pop
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers; reset flushes the contents
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written at the tail
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/pixel_stream_packer.sv
// Turns the raster pixel feed into a stream with start-of-frame and
// end-of-line tags. Admission only begins on a frame boundary, and after an
// overflow the stream resynchronises at the next frame.
module pixel_stream_packer
    import game_pkg::*;
#(
    parameter int          COLOR_BITS      = COLOR_BITS_DEF,
    parameter int          H_ACTIVE        = H_ACTIVE_DEF,
    parameter int          V_ACTIVE        = V_ACTIVE_DEF,
    parameter int          FIFO_DEPTH      = 16,
    parameter logic [15:0] FRAME_COUNT_RST = 16'd0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    display_enable_i,
    input  logic [9:0]              hpos_i,
    input  logic [9:0]              vpos_i,
    input  logic [COLOR_BITS/3-1:0] red_i,
    input  logic [COLOR_BITS/3-1:0] green_i,
    input  logic [COLOR_BITS/3-1:0] blue_i,
    output logic [COLOR_BITS-1:0]   tdata_o,
    output logic                    tuser_o,
    output logic                    tlast_o,
    output logic                    tvalid_o,
    input  logic                    tready_i,
    output logic                    overflow_o,
    output logic [15:0]             frame_count_o
);
    localparam int ENTRY_W = COLOR_BITS + 2;

    // Reject configurations the raster counters or the FIFO cannot support
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pixel_stream_packer: FIFO_DEPTH must be a power of two >= 4");
    end
    if (H_ACTIVE < 1 || H_ACTIVE > 1024 || V_ACTIVE < 1 || V_ACTIVE > 1024) begin : g_bad_raster
        $error("pixel_stream_packer: active area must fit 10-bit coordinates");
    end

    pk_state_e          state_q, state_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               pix_sof, pix_eol;
    logic               fifo_full, fifo_empty;
    logic               pop, can_push, push, drop;
    logic [ENTRY_W-1:0] push_entry, head_entry;

    assign pix_sof    = (hpos_i == 10'd0) && (vpos_i == 10'd0);
    assign pix_eol    = (hpos_i == 10'(H_ACTIVE - 1));
    assign pop        = !fifo_empty && tready_i;
    assign can_push   = !fifo_full || pop;
    // Same {sof, eol, rgb} layout as pix_entry_t
    assign push_entry = {pix_sof, pix_eol, red_i, green_i, blue_i};

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= WAIT_SOF;
        else       state_q <= state_d;
    end

    // Next state: leave STREAM on a lost pixel, re-enter only on a frame start that fits
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (display_enable_i && pix_sof && can_push) state_d = STREAM;
            STREAM:   if (display_enable_i && !can_push)           state_d = DROP;
            DROP:     if (display_enable_i && pix_sof && can_push) state_d = STREAM;
            default:  state_d = WAIT_SOF;
        endcase
    end

    // Outputs of the FSM: push/drop decision plus sticky overflow and frame counter
    always_comb begin
        push = 1'b0;
        drop = 1'b0;
        case (state_q)
            WAIT_SOF, DROP: push = display_enable_i && pix_sof && can_push;
            STREAM: begin
                push = display_enable_i && can_push;
                drop = display_enable_i && !can_push;
            end
            default: ;
        endcase
        overflow_d  = overflow_q | drop;
        frame_cnt_d = frame_cnt_q + {15'd0, push & pix_sof};
    end

    // Status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q  <= 1'b0;
            frame_cnt_q <= FRAME_COUNT_RST;
        end else begin
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head_entry)
    );

    assign tvalid_o      = !fifo_empty;
    assign tuser_o       = head_entry[ENTRY_W-1];
    assign tlast_o       = head_entry[ENTRY_W-2];
    assign tdata_o       = head_entry[COLOR_BITS-1:0];
    assign overflow_o    = overflow_q;
    assign frame_count_o = frame_cnt_q;

endmodule
